// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush scheduler for the 5-stage pipeline
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             branch_exmem,
    input  logic             zero_exmem,
    input  logic             jump_exmem,
    input  logic             mem_read_exmem,
    input  logic             mem_write_exmem,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q;
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

    logic mem_op, redirect, load_use, freeze, redirect_eff, load_use_eff, stall_now;

    assign mem_op   = mem_read_exmem | mem_write_exmem;
    assign redirect = (branch_exmem & zero_exmem) | jump_exmem;
    assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    always_comb begin
        freeze = 1'b0;
        case (state_q)
            RUN:      freeze = mem_op & ~dmem_ack;
            MEM_WAIT: freeze = ~dmem_ack;
            default:  freeze = 1'b1;
        endcase
    end

    assign redirect_eff = ~freeze & redirect;
    assign load_use_eff = ~freeze & ~redirect & load_use;
    assign stall_now    = freeze | load_use_eff;

    // Controls are combinational but forced low while reset is held.
    assign dmem_req    = rst_n & (((state_q == RUN) & mem_op) | (state_q == MEM_WAIT));
    assign pc_write    = rst_n & ~stall_now;
    assign ifid_write  = rst_n & ~stall_now;
    assign ifid_flush  = rst_n & redirect_eff;
    assign idex_flush  = rst_n & redirect_eff;
    assign idex_bubble = rst_n & load_use_eff;
    assign exmem_hold  = rst_n & freeze;

    // wait_cnt counts request cycles seen; the cycle that would make it
    // reach MEM_TIMEOUT without an ack moves to ERROR.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_op && !dmem_ack) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_q == 8'(MEM_TIMEOUT - 1))
                        state_d = ERROR;
                end
            end
            default: state_d = ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wait_cnt_q     <= 8'd0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_q == ERROR)
                mem_timeout_q <= 1'b1;
            if (stall_now && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            if (redirect_eff && (flush_count_q != '1))
                flush_count_q <= flush_count_q + CNT_W'(1);
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       ifid_rs, ifid_rt, idex_rt;
    logic             idex_mem_read, branch_exmem, zero_exmem, jump_exmem;
    logic             mem_read_exmem, mem_write_exmem, dmem_ack;
    logic             dmem_req, pc_write, ifid_write, ifid_flush;
    logic             idex_bubble, idex_flush, exmem_hold, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .branch_exmem(branch_exmem), .zero_exmem(zero_exmem), .jump_exmem(jump_exmem),
        .mem_read_exmem(mem_read_exmem), .mem_write_exmem(mem_write_exmem),
        .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_flush(idex_flush), .exmem_hold(exmem_hold),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Control vector order: {dmem_req, pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, exmem_hold}
    localparam logic [6:0] C_RESET = 7'b0000000;
    localparam logic [6:0] C_IDLE  = 7'b0110000;
    localparam logic [6:0] C_LU    = 7'b0000100;
    localparam logic [6:0] C_REDIR = 7'b0111010;
    localparam logic [6:0] C_FRZ   = 7'b1000001;
    localparam logic [6:0] C_ACK   = 7'b1110000;
    localparam logic [6:0] C_ERR   = 7'b0000001;

    typedef struct {
        logic [6:0] ctl;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [6:0] ctl_now();
        return {dmem_req, pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, exmem_hold};
    endfunction

    task automatic expect_ctl(input logic [6:0] ctl, input string tag);
        exp_t e;
        e.ctl = ctl;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Settle, compare the oldest scoreboard entry, optionally advance one edge.
    task automatic check_ctl(input bit adv);
        exp_t e;
        #1;
        e = sb.pop_front();
        n_assert++;
        assert (ctl_now() === e.ctl) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", e.tag, ctl_now(), e.ctl);
        end
        if (adv) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cyc(input logic [6:0] ctl, input string tag);
        expect_ctl(ctl, tag);
        check_ctl(1'b1);
    endtask

    task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0; idex_mem_read = 1'b0;
        branch_exmem = 1'b0; zero_exmem = 1'b0; jump_exmem = 1'b0;
        mem_read_exmem = 1'b0; mem_write_exmem = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rt);
        idex_mem_read = 1'b1; idex_rt = rt; ifid_rs = rt;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        mem_read_exmem = 1'b1;
        #12;
        expect_ctl(C_RESET, "reset_ctl");
        check_ctl(1'b0);
        chk("reset_stall", stall_cycles, 4'd0);
        chk("reset_flush", flush_count, 4'd0);
        chk("reset_timeout", {3'b0, mem_timeout}, 4'd0);

        rst_n = 1'b1;
        expect_ctl(C_FRZ, "post_reset_freeze");
        check_ctl(1'b0);
        dmem_ack = 1'b1;
        cyc(C_ACK, "zero_wait_ack");
        chk("zero_wait_stall", stall_cycles, 4'd0);

        idle();
        cyc(C_IDLE, "idle");
        set_lu(5'd5);
        cyc(C_LU, "load_use");
        idle();
        cyc(C_IDLE, "after_bubble");
        chk("lu_stall", stall_cycles, 4'd1);
        set_lu(5'd0);
        cyc(C_IDLE, "lu_rt0");
        chk("lu_rt0_stall", stall_cycles, 4'd1);

        set_lu(5'd5);
        branch_exmem = 1'b1; zero_exmem = 1'b1;
        cyc(C_REDIR, "branch_taken");
        chk("branch_flush", flush_count, 4'd1);
        chk("branch_no_stall", stall_cycles, 4'd1);
        idle();
        branch_exmem = 1'b1;
        cyc(C_IDLE, "branch_not_taken");
        chk("bnt_flush", flush_count, 4'd1);
        idle();
        jump_exmem = 1'b1;
        cyc(C_REDIR, "jump");
        chk("jump_flush", flush_count, 4'd2);

        idle();
        mem_write_exmem = 1'b1;
        for (int i = 0; i < 3; i++) cyc(C_FRZ, "store_wait");
        dmem_ack = 1'b1;
        cyc(C_ACK, "store_ack");
        idle();
        cyc(C_IDLE, "store_done");
        chk("store_stall", stall_cycles, 4'd4);

        mem_read_exmem = 1'b1;
        for (int i = 0; i < 3; i++) cyc(C_FRZ, "ack_race_wait");
        dmem_ack = 1'b1;
        cyc(C_ACK, "ack_beats_timeout");
        idle();
        cyc(C_IDLE, "ack_race_done");
        chk("ack_race_stall", stall_cycles, 4'd7);

        set_lu(5'd9);
        for (int i = 0; i < 20; i++) cyc(C_LU, "lu_sat");
        idle();
        cyc(C_IDLE, "sat_done");
        chk("stall_saturate", stall_cycles, 4'd15);

        mem_read_exmem = 1'b1;
        for (int i = 0; i < 4; i++) cyc(C_FRZ, "timeout_wait");
        cyc(C_ERR, "error_entry");
        dmem_ack = 1'b1;
        cyc(C_ERR, "error_ignores_ack");
        idle();
        set_lu(5'd3);
        cyc(C_ERR, "error_holds");
        chk("mem_timeout_set", {3'b0, mem_timeout}, 4'd1);
        chk("error_stall_sat", stall_cycles, 4'd15);

        idle();
        mem_read_exmem = 1'b1;
        #2;
        rst_n = 1'b0;
        expect_ctl(C_RESET, "async_reset");
        check_ctl(1'b0);
        chk("async_reset_stall", stall_cycles, 4'd0);
        chk("async_reset_flush", flush_count, 4'd0);
        chk("async_reset_timeout", {3'b0, mem_timeout}, 4'd0);
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        cyc(C_IDLE, "recovered");
        chk("recovered_timeout", {3'b0, mem_timeout}, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage MIPS pipeline. It detects load-use hazards between ID/EX and IF/ID, and redirects from taken branches or jumps resolved in EX/MEM. It also holds the pipeline while the data memory completes a request/acknowledge handshake. Its outputs drive the PC write enable, the IF/ID write enable and flush, the ID/EX bubble and flush, and the EX/MEM hold, and it keeps saturating stall and flush statistics.

## Interface
- MEM_TIMEOUT, 16: consecutive unacknowledged dmem_req cycles before entering ERROR (range 2..255).
- CNT_W, 32: width of statistics counters.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ifid_rs  in  5  rs field of instruction in IF/ID
- ifid_rt  in  5  rt field of instruction in IF/ID
- idex_mem_read  in  1  ID/EX instruction is a load
- idex_rt  in  5  load destination register in ID/EX
- branch_exmem  in  1  EX/MEM holds a branch
- zero_exmem  in  1  ALU zero flag registered in EX/MEM
- jump_exmem  in  1  EX/MEM holds a jump
- mem_read_exmem  in  1  EX/MEM holds a load
- mem_write_exmem  in  1  EX/MEM holds a store
- dmem_ack  in  1  data memory completes the current request this cycle
- dmem_req  out  1  data memory request strobe
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  clear IF/ID to NOP at next edge
- idex_bubble  out  1  zero ID/EX control bits at next edge (load-use)
- idex_flush  out  1  clear ID/EX to NOP at next edge (redirect)
- exmem_hold  out  1  EX/MEM and ID/EX retain contents
- mem_timeout  out  1  sticky error flag, registered
- stall_cycles  out  CNT_W  cycles with pc_write=0 since reset, saturating
- flush_count  out  CNT_W  redirects taken since reset, saturating

## Operation
- State machine: RUN, MEM_WAIT, ERROR. The state register and wait_cnt are reset to RUN and 0.
- Control outputs are Mealy, derived from state and current inputs. The counters and mem_timeout are registered.
- mem_op = mem_read_exmem | mem_write_exmem.
- redirect = (branch_exmem & zero_exmem) | jump_exmem.
- load_use = idex_mem_read & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- freeze condition:
  - In RUN: mem_op & !dmem_ack.
  - In MEM_WAIT: !dmem_ack.
  - In ERROR: always.
- Priority per cycle: freeze > redirect > load_use. Default outputs are pc_write=1 and ifid_write=1, with all other outputs 0.
- dmem_req is 1 in RUN when mem_op=1, and 1 in MEM_WAIT. It is 0 in ERROR.
- On freeze: pc_write=0, ifid_write=0, exmem_hold=1, and no flush or bubble is issued.
- On redirect (no freeze): ifid_flush=1, idex_flush=1, pc_write=1. load_use is ignored. flush_count increments.
- On load_use (no freeze, no redirect): pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle.
- RUN to MEM_WAIT on mem_op & !dmem_ack, with wait_cnt set to 1.
- MEM_WAIT behaviour:
  - On dmem_ack: go to RUN. This cycle is unfrozen and the other rules apply normally.
  - Otherwise, wait_cnt increments.
  - When wait_cnt==MEM_TIMEOUT and no ack: go to ERROR.
- An ack in the same cycle always beats the timeout.
- ERROR asserts mem_timeout=1 from the next edge. The block stays in ERROR until rst_n is asserted.
- Both counters saturate at all-ones and never wrap. stall_cycles also counts in ERROR.

## Timing
- While rst_n=0:
  - pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, exmem_hold and dmem_req are all 0.
  - mem_timeout=0, stall_cycles=0, flush_count=0.
- First edge after rst_n rises: RUN, with default outputs.
- Zero-wait memory: dmem_ack in the same cycle as dmem_req gives no stall.
- With dmem_ack N cycles after the first request cycle (N < MEM_TIMEOUT):
  - The pipeline freezes for N cycles and resumes in the ack cycle.
  - stall_cycles increases by N.
- Load-use costs exactly 1 stall cycle. The following cycle has load_use=0 because the bubble removed the load from ID/EX.
- A redirect costs 0 freeze cycles and 2 flushed slots.
- If reset is asserted mid-MEM_WAIT, the block returns to RUN asynchronously, dmem_req drops at once, and all counters clear.

## Test plan
- Reset with mem_op=1 and ack low: all outputs 0 during reset. After release, RUN, dmem_req=1, freeze asserted.
- Load-use: idex_mem_read=1, idex_rt=5, ifid_rs=5, everything else idle.
  - One cycle of pc_write=0, ifid_write=0, idex_bubble=1, then defaults.
  - stall_cycles=1.
  - Repeat with idex_rt=0: no stall.
- Branch taken: branch_exmem=1, zero_exmem=1, together with the load_use condition.
  - ifid_flush=idex_flush=1, no bubble.
  - flush_count=1.
  - Repeat with zero_exmem=0: no flush.
- Store with ack after 3 cycles: dmem_req high for 4 cycles, exmem_hold=1 for the first 3, stall_cycles=3, back to RUN.
- Timeout with MEM_TIMEOUT=4 and ack never arriving:
  - ERROR entered after 4 request cycles; mem_timeout=1 from the next edge.
  - dmem_req=0, freeze held indefinitely.
  - Only rst_n low recovers.
- Counter saturation with CNT_W=4: 20 load-use stalls leave stall_cycles=15.
